// File: rtl/seg7_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// seg7_pkg : scan FSM state type and active-low {g,f,e,d,c,b,a} patterns
// Rev 1.0
// ----------------------------------------------------------------------
package seg7_pkg;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage
`default_nettype wire

// File: rtl/hex_seg_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------
// hex_seg_decoder : combinational hex nibble to active-low segment pattern
// Rev 1.0
// ----------------------------------------------------------------------
module hex_seg_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------
// seg7_scan_ctrl : multiplexed common-anode 7-segment scanner with
//                  frame-aligned single-entry load buffer
// Rev 1.0
// ----------------------------------------------------------------------
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int DWELL     = 50000,
  parameter int BLANK_CYC = 500
)(
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] value,
  input  logic                load,
  input  logic                blank_lz,
  output logic                ready,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg,
  output logic                frame_done
);

  localparam int MAX_CYC = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] active_q, active_d, pending_q;
  logic                ready_q, frame_done_q;
  logic [DIGITS-1:0]   an_q;
  logic [6:0]          seg_q;

  logic                w_cnt_done, w_wrap, w_upper_zero, w_lz_blank;
  logic [3:0]          w_nib;
  logic [6:0]          w_seg;
  logic [DIGITS-1:0]   w_an_lit;

  // Slot outputs are decoded from the post-transfer word, so the frame that
  // starts on the frame_done edge is entirely old or entirely new.
  always_comb begin
    w_cnt_done   = (state_q == BLANK) ? (cnt_q == BLANK_LAST) : (cnt_q == DWELL_LAST);
    w_wrap       = (state_q == BLANK) && w_cnt_done && (idx_q == IDX_LAST);
    idx_d        = w_wrap ? '0 : idx_q + IDX_W'(1);
    active_d     = (w_wrap && !ready_q) ? pending_q : active_q;
    w_nib        = 4'h0;
    w_upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == int'(idx_d))
        w_nib = active_d[4*i +: 4];
      if ((i >= int'(idx_d)) && (active_d[4*i +: 4] != 4'h0))
        w_upper_zero = 1'b0;
    end
    w_lz_blank = blank_lz && (idx_d != '0) && w_upper_zero;
    w_an_lit   = ~(DIGITS'(1) << idx_d);
  end

  hex_seg_decoder u_hex_seg_decoder (
    .hex_i (w_nib),
    .seg_o (w_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BLANK;
      cnt_q        <= '0;
      idx_q        <= IDX_LAST;
      active_q     <= '0;
      pending_q    <= '0;
      ready_q      <= 1'b1;
      frame_done_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
    end else begin
      frame_done_q <= 1'b0;
      active_q     <= active_d;
      if (w_wrap && !ready_q) begin
        ready_q <= 1'b1;
      end else if (load && ready_q) begin
        pending_q <= value;
        ready_q   <= 1'b0;
      end
      if (w_cnt_done) begin
        cnt_q <= '0;
        if (state_q == BLANK) begin
          state_q      <= SHOW;
          idx_q        <= idx_d;
          frame_done_q <= w_wrap;
          an_q         <= w_lz_blank ? '1 : w_an_lit;
          seg_q        <= w_lz_blank ? SEG_OFF : w_seg;
        end else begin
          state_q <= BLANK;
          an_q    <= '1;
          seg_q   <= SEG_OFF;
        end
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign ready      = ready_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_seg7_scan_ctrl : scoreboard bench with a frame-arithmetic display model
// Rev 1.0
// ----------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int DIGITS    = 4;
  localparam int DWELL     = 4;
  localparam int BLANK_CYC = 2;
  localparam int SLOT      = DWELL + BLANK_CYC;
  localparam int FRAME     = DIGITS * SLOT;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       ready;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        ready;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  seg7_scan_ctrl #(
    .DIGITS    (DIGITS),
    .DWELL     (DWELL),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .load       (load),
    .blank_lz   (blank_lz),
    .ready      (ready),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the frame follows from edges since reset.
  int          m_k = 0;
  bit          m_pend_v = 0;
  logic [15:0] m_pending = '0;
  logic [15:0] m_active = '0;
  logic [3:0]  m_an = 4'hF;
  logic [6:0]  m_seg = 7'h7F;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_k = 0; m_pend_v = 0; m_pending = '0; m_active = '0;
        m_an = 4'hF; m_seg = 7'h7F;
        sb.delete();
      end else begin
        bit          acc, lz_in, fd;
        logic [15:0] v_in;
        logic [3:0]  nib;
        int          p, s, off;
        acc   = load && !m_pend_v;
        lz_in = blank_lz;
        v_in  = value;
        m_k++;
        p   = m_k % FRAME;
        s   = p / SLOT;
        off = p % SLOT;
        fd  = (p == BLANK_CYC);
        if (fd && m_pend_v) begin
          m_active = m_pending;
          m_pend_v = 0;
        end
        if (acc) begin
          m_pending = v_in;
          m_pend_v  = 1;
        end
        if (off < BLANK_CYC) begin
          m_an = 4'hF; m_seg = 7'h7F;
        end else if (off == BLANK_CYC) begin
          nib = m_active[4*s +: 4];
          if (lz_in && s != 0 && (m_active >> (4*s)) == 16'h0) begin
            m_an = 4'hF; m_seg = 7'h7F;
          end else begin
            m_an  = ~(4'b0001 << s);
            m_seg = HEX_TAB[nib];
          end
        end
        sb.push_back('{m_an, m_seg, !m_pend_v, fd});
      end
    end
  end

  initial begin
    forever begin
      @(negedge rst);
      sb.push_back('{4'hF, 7'h7F, 1'b1, 1'b0});
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_ready", 32'(ready), 32'h1);
        check("rst_frame_done", 32'(frame_done), 32'h0);
      end else if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got no expected entry at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("an", 32'(an), 32'(e.an));
        check("seg", 32'(seg), 32'(e.seg));
        check("ready", 32'(ready), 32'(e.ready));
        check("frame_done", 32'(frame_done), 32'(e.fd));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    @(negedge clk);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_fd();
    bit ok = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_frame_done: got timeout expected pulse at %0t", $time);
    end
  endtask

  task automatic wait_an(input logic [3:0] pat);
    bit ok = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (an === pat) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_an: got timeout expected an=%b at %0t", pat, $time);
    end
  endtask

  initial begin
    cycles(3);
    @(posedge clk); #2 rst = 1'b0;
    cycles(2 * FRAME);

    do_load(16'h12A5);
    do_load(16'hFFFF);
    cycles(3 * FRAME);

    blank_lz = 1'b1;
    do_load(16'h0007);
    cycles(3 * FRAME);
    do_load(16'h0000);
    cycles(3 * FRAME);
    do_load(16'h0304);
    cycles(3 * FRAME);

    wait_fd();
    value = 16'hBEEF;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    cycles(3 * FRAME);

    for (int n = 0; n < 40; n++) begin
      cycles($urandom_range(0, 50));
      blank_lz = 1'($urandom_range(0, 1));
      do_load(16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 3))));
    end
    cycles(3 * FRAME);

    wait_fd();
    do_load(16'h9876);
    wait_an(4'b1011);
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    blank_lz = 1'b0;
    cycles(3 * FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
